// File: rtl/apb_decode_router_pkg.sv
// Shared types for the APB decode router and its selector.
// Request/response structs use maximum widths; instances cast down to their own ADDR_W/DATA_W.
package apb_decode_router_pkg;

  localparam int MAX_ADDR_W = 64;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_SEL_W  = 8;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
    logic [MAX_SEL_W-1:0]  idx;
  } req_t;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  err;
  } rsp_t;

  // Mask of the address bits below lsb, i.e. the in-block offset.
  function automatic logic [MAX_ADDR_W-1:0] low_mask(input int unsigned lsb);
    low_mask = (MAX_ADDR_W'(1) << lsb) - MAX_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/apb_decode_sel.sv
// Slave-select decode (index, decode error, in-block offset) and read-data mux.
// Purely combinational so it can be stacked in multi-level decoders.
module apb_decode_sel
  import apb_decode_router_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SEL_LSB    = 12,
  parameter int SEL_W      = 2
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic [SEL_W-1:0]             rd_idx,
  input  logic [NUM_SLAVES*DATA_W-1:0] m_prdata,
  output logic [SEL_W-1:0]             idx,
  output logic                         dec_err,
  output logic [ADDR_W-1:0]            offset,
  output logic [DATA_W-1:0]            rdata
);

  localparam int HI_LSB = SEL_LSB + SEL_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(low_mask(SEL_LSB));

  logic hi_set;

  assign idx    = addr[SEL_LSB +: SEL_W];
  assign offset = addr & OFF_MASK;

  // Any address bit above the select field makes the address unmapped.
  generate
    if (HI_LSB < ADDR_W) begin : g_hi
      assign hi_set = |addr[ADDR_W-1:HI_LSB];
    end else begin : g_no_hi
      assign hi_set = 1'b0;
    end
  endgenerate

  assign dec_err = hi_set || (32'(idx) >= 32'(NUM_SLAVES));

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (32'(rd_idx) == i) rdata = m_prdata[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/apb_decode_router.sv
// Routes one upstream APB request to one of NUM_SLAVES downstream APB ports.
// Optional ACCESS timeout enabled by defining APB_DECODE_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for upstream setup phase; decodes and latches the request
// ST_SETUP  | downstream setup phase (m_psel high, m_penable low)
// ST_ACCESS | downstream access phase, waiting for the selected m_pready
// ST_RESP   | upstream s_pready high for one cycle with the captured response
module apb_decode_router
  import apb_decode_router_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SEL_LSB        = 12,
  parameter int SEL_W          = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_psel,
  input  logic                         s_penable,
  input  logic                         s_pwrite,
  input  logic [ADDR_W-1:0]            s_paddr,
  input  logic [DATA_W-1:0]            s_pwdata,
  output logic                         s_pready,
  output logic [DATA_W-1:0]            s_prdata,
  output logic                         s_pslverr,
  output logic [NUM_SLAVES-1:0]        m_psel,
  output logic                         m_penable,
  output logic                         m_pwrite,
  output logic [ADDR_W-1:0]            m_paddr,
  output logic [DATA_W-1:0]            m_pwdata,
  input  logic [NUM_SLAVES-1:0]        m_pready,
  input  logic [NUM_SLAVES*DATA_W-1:0] m_prdata,
  input  logic [NUM_SLAVES-1:0]        m_pslverr,
  output logic [7:0]                   err_count
);

  generate
    if (NUM_SLAVES < 1 || NUM_SLAVES > (1 << SEL_W) || ADDR_W > MAX_ADDR_W ||
        DATA_W > MAX_DATA_W || SEL_W > MAX_SEL_W || SEL_LSB + SEL_W > ADDR_W ||
        TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("apb_decode_router: illegal parameter combination");
    end
  endgenerate

  state_e                state_q, state_d;
  req_t                  req_q, req_d;
  rsp_t                  rsp_q, rsp_d;
  logic                  s_pready_q, s_pready_d;
  logic [NUM_SLAVES-1:0] m_psel_q, m_psel_d;
  logic                  m_penable_q, m_penable_d;
  logic                  m_pwrite_q, m_pwrite_d;
  logic [ADDR_W-1:0]     m_paddr_q, m_paddr_d;
  logic [DATA_W-1:0]     m_pwdata_q, m_pwdata_d;
  logic [7:0]            err_count_q, err_count_d;
  logic                  err_inc;

  logic [ADDR_W-1:0]     dec_addr;
  logic [ADDR_W-1:0]     dec_offset;
  logic [SEL_W-1:0]      dec_idx;
  logic                  dec_err;
  logic [DATA_W-1:0]     sel_rdata;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  sel_ready;
  logic                  sel_err;

`ifdef APB_DECODE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Decode the live upstream address in IDLE, the latched one afterwards.
  assign dec_addr = (state_q == ST_IDLE) ? s_paddr : ADDR_W'(req_q.addr);

  apb_decode_sel #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .SEL_LSB    (SEL_LSB),
    .SEL_W      (SEL_W)
  ) u_sel (
    .addr     (dec_addr),
    .rd_idx   (SEL_W'(req_q.idx)),
    .m_prdata (m_prdata),
    .idx      (dec_idx),
    .dec_err  (dec_err),
    .offset   (dec_offset),
    .rdata    (sel_rdata)
  );

  always_comb begin
    dec_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_onehot[i] = (32'(dec_idx) == i);
    end
  end

  // m_psel_q is one-hot on the latched index, so masking ignores other slaves.
  assign sel_ready = |(m_pready & m_psel_q);
  assign sel_err   = |(m_pslverr & m_psel_q);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_d       = rsp_q;
    s_pready_d  = 1'b0;
    m_psel_d    = m_psel_q;
    m_penable_d = m_penable_q;
    m_pwrite_d  = m_pwrite_q;
    m_paddr_d   = m_paddr_q;
    m_pwdata_d  = m_pwdata_q;
    err_inc     = 1'b0;
`ifdef APB_DECODE_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        rsp_d = '0;
        if (s_psel && !s_penable) begin
          req_d.write = s_pwrite;
          req_d.addr  = MAX_ADDR_W'(s_paddr);
          req_d.wdata = MAX_DATA_W'(s_pwdata);
          req_d.idx   = MAX_SEL_W'(dec_idx);
          if (dec_err) begin
            state_d    = ST_RESP;
            s_pready_d = 1'b1;
            rsp_d.err  = 1'b1;
            err_inc    = 1'b1;
          end else begin
            state_d     = ST_SETUP;
            m_psel_d    = dec_onehot;
            m_penable_d = 1'b0;
            m_pwrite_d  = s_pwrite;
            m_paddr_d   = dec_offset;
            m_pwdata_d  = s_pwdata;
          end
        end
      end
      ST_SETUP: begin
        state_d     = ST_ACCESS;
        m_penable_d = 1'b1;
        m_pwrite_d  = req_q.write;
        m_paddr_d   = dec_offset;
        m_pwdata_d  = DATA_W'(req_q.wdata);
`ifdef APB_DECODE_TIMEOUT_EN
        tmo_cnt_d   = TMO_W'(TIMEOUT_CYCLES - 1);
`endif
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          state_d     = ST_RESP;
          m_psel_d    = '0;
          m_penable_d = 1'b0;
          s_pready_d  = 1'b1;
          rsp_d.err   = sel_err;
          rsp_d.data  = req_q.write ? '0 : MAX_DATA_W'(sel_rdata);
          err_inc     = sel_err;
        end
`ifdef APB_DECODE_TIMEOUT_EN
        // Terminal count reached on the last allowed ACCESS cycle: abort.
        else if (tmo_cnt_q == '0) begin
          state_d     = ST_RESP;
          m_psel_d    = '0;
          m_penable_d = 1'b0;
          s_pready_d  = 1'b1;
          rsp_d.err   = 1'b1;
          rsp_d.data  = MAX_DATA_W'(TIMEOUT_DATA);
          err_inc     = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        rsp_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    err_count_d = (err_inc && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      s_pready_q  <= 1'b0;
      m_psel_q    <= '0;
      m_penable_q <= 1'b0;
      m_pwrite_q  <= 1'b0;
      m_paddr_q   <= '0;
      m_pwdata_q  <= '0;
      err_count_q <= '0;
`ifdef APB_DECODE_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_q       <= rsp_d;
      s_pready_q  <= s_pready_d;
      m_psel_q    <= m_psel_d;
      m_penable_q <= m_penable_d;
      m_pwrite_q  <= m_pwrite_d;
      m_paddr_q   <= m_paddr_d;
      m_pwdata_q  <= m_pwdata_d;
      err_count_q <= err_count_d;
`ifdef APB_DECODE_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign s_pready  = s_pready_q;
  assign s_prdata  = DATA_W'(rsp_q.data);
  assign s_pslverr = rsp_q.err;
  assign m_psel    = m_psel_q;
  assign m_penable = m_penable_q;
  assign m_pwrite  = m_pwrite_q;
  assign m_paddr   = m_paddr_q;
  assign m_pwdata  = m_pwdata_q;
  assign err_count = err_count_q;

endmodule
